mac_seq_ctrl: RTL and testbench
===============================

Name: mac_seq_ctrl

Overview:
- Sequencer that drives the 8-bit signed conv2d MAC unit for one output pixel.
- Clears the MAC accumulator and injects the bias through the MAC's only_add path.
- Streams n_taps activation/weight pairs from two synchronous-read buffers into the MAC.
- Captures the MAC's quantized 8-bit output and presents it on a valid/ready result port for the output buffer writer.

Parameters:
- KMAX, 9, maximum taps per pixel; n_taps inputs above this are clamped to KMAX.
- ADDR_W, 8, activation/weight buffer address width.

Ports:
- clk  input  1  clock
- rstn  input  1  synchronous active-low reset
- start  input  1  pulse; begin one pixel; sampled only in IDLE
- n_taps  input  4  tap count (0..KMAX), latched on start
- act_base  input  ADDR_W  activation start address, latched on start
- wgt_base  input  ADDR_W  weight start address, latched on start
- bias  input  8  signed bias in output units, latched on start
- busy  output  1  high from the cycle after start is accepted until the result handshake completes
- rd_en  output  1  buffer read strobe; both buffers
- act_addr  output  ADDR_W  activation read address
- wgt_addr  output  ADDR_W  weight read address
- act_rdata  input  8  signed; valid the cycle after rd_en
- wgt_rdata  input  8  signed; valid the cycle after rd_en
- mac_clr_n  output  1  to MAC rstn; low clears the accumulator
- mac_en  output  1  to MAC enable
- mac_only_add  output  1  to MAC only_add
- mac_a  output  8  to MAC din_a
- mac_b  output  8  to MAC din_b
- mac_dout  input  8  MAC quantized output; combinational from the MAC accumulator
- res_valid  output  1  result valid
- res_ready  input  1  result accepted when res_valid and res_ready are both high
- res_data  output  8  result; stable while res_valid is high

Behaviour:
- Reset (rstn=0 at a clk edge): state IDLE; counters, latched inputs and res_data cleared to 0; busy=0, rd_en=0, mac_en=0, mac_only_add=0, res_valid=0; mac_clr_n=0 (MAC held cleared); addresses=0.
- Reset mid-operation aborts immediately; the partial result is discarded.
- Outside reset, mac_clr_n=1 except in CLR.
- States: IDLE -> CLR -> RUN -> DRAIN -> CAP -> OUT -> IDLE.
- IDLE: on start=1, latch n_taps, act_base, wgt_base, bias; go to CLR. start is ignored in every other state.
- CLR (1 cycle): mac_clr_n=0; the accumulator is 0 after the edge.
- RUN (max(n_taps,1) cycles, index i=0..):
  - Cycle i=0: mac_en=1, mac_only_add=1, mac_a=bias, mac_b=0; the MAC adds bias<<<8.
  - Cycle i<n_taps: rd_en=1, act_addr=act_base+i, wgt_addr=wgt_base+i; addresses wrap modulo 2^ADDR_W.
  - Tap pipeline: a one-cycle delayed copy of rd_en (tap_v) drives mac_en=1, mac_only_add=0, mac_a=act_rdata, mac_b=wgt_rdata.
  - The bias cycle and the first tap_v cycle never overlap, because tap_v first rises at i=1.
- DRAIN (1 cycle): the final tap_v MAC update; for n_taps=0 this is an idle cycle.
- CAP (1 cycle): mac_dout reflects the full sum; register it into res_data.
- OUT: res_valid=1 and res_data held until res_ready=1; then return to IDLE, with busy=0 the next cycle. A start in that next cycle is accepted.
- Latency: start sampled in cycle 0 -> res_valid high from cycle max(n_taps,1)+4. Examples: 13 for n_taps=9; 5 for n_taps=0.
- Back-to-back: minimum pixel period is latency+1 cycles with res_ready tied high.
- Clamping: n_taps>KMAX is treated as KMAX.
- Arithmetic: no arithmetic in this block beyond address increment. Saturation, ReLU and quantization are owned by the MAC; res_data is mac_dout verbatim.
- Output drive: mac_a/mac_b/mac_en/mac_only_add are combinational from registered state and tap_v. They are 0/0/0/0 whenever no bias or tap cycle is active.
- res_ready while res_valid=0: ignored.

Test Plan:
- Reset: hold rstn=0 for 3 cycles with start=1 -> busy=0, res_valid=0, mac_clr_n=0, rd_en=0, mac_en=0; release -> stays IDLE until the next start pulse.
- n_taps=9, act=16, wgt=16 for all taps, bias=0, res_ready=1 -> 9 rd_en cycles with addresses base..base+8; res_valid at cycle 13; res_data=9.
- n_taps=9, act=16, wgt=-16, bias=2 -> accumulator negative; res_data=0; exactly one mac_only_add cycle, carrying mac_a=2.
- n_taps=0, bias=7 -> no rd_en; res_valid at cycle 5; res_data=7.
- act_base=254, n_taps=4 -> act_addr sequence 254, 255, 0, 1.
- Backpressure: res_ready=0 for 5 cycles with start pulsed -> res_data stable, busy=1, start ignored; res_ready=1 -> handshake; a start the following cycle is accepted.
- Reset asserted in RUN at i=3 -> next cycle IDLE, rd_en=0, mac_en=0, mac_clr_n=0; a fresh start gives the correct result with no residue from the aborted pixel.

Source files
------------

// File: rtl/mac_seq_ctrl.sv
// Sequencer for the signed 8-bit conv2d MAC: clears the accumulator, injects the
// bias, streams n_taps buffer pairs, then returns the quantized pixel over valid/ready.
module mac_seq_ctrl #(
  parameter int KMAX   = 9,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [3:0]        n_taps,
  input  logic [ADDR_W-1:0] act_base,
  input  logic [ADDR_W-1:0] wgt_base,
  input  logic [7:0]        bias,
  output logic              busy,
  output logic              rd_en,
  output logic [ADDR_W-1:0] act_addr,
  output logic [ADDR_W-1:0] wgt_addr,
  input  logic [7:0]        act_rdata,
  input  logic [7:0]        wgt_rdata,
  output logic              mac_clr_n,
  output logic              mac_en,
  output logic              mac_only_add,
  output logic [7:0]        mac_a,
  output logic [7:0]        mac_b,
  input  logic [7:0]        mac_dout,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [7:0]        res_data
);

  typedef enum logic [2:0] {IDLE, CLR, RUN, DRAIN, CAP, OUT} state_t;

  state_t            state, state_nx;
  logic [3:0]        cnt;
  logic [3:0]        n_q;
  logic [3:0]        last_idx;
  logic [ADDR_W-1:0] act_base_q;
  logic [ADDR_W-1:0] wgt_base_q;
  logic [7:0]        bias_q;
  logic              tap_v;
  logic              clr_n_q;

  // RUN always lasts at least one cycle so the bias still gets injected when n_taps=0.
  assign last_idx = (n_q == 4'd0) ? 4'd0 : n_q - 4'd1;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt        <= '0;
      n_q        <= '0;
      act_base_q <= '0;
      wgt_base_q <= '0;
      bias_q     <= '0;
      tap_v      <= 1'b0;
      clr_n_q    <= 1'b0;
      res_data   <= '0;
    end else begin
      clr_n_q <= 1'b1;
      tap_v   <= rd_en;
      if (state == IDLE && start) begin
        cnt        <= '0;
        n_q        <= (n_taps > 4'(KMAX)) ? 4'(KMAX) : n_taps;
        act_base_q <= act_base;
        wgt_base_q <= wgt_base;
        bias_q     <= bias;
      end
      if (state == RUN) cnt <= cnt + 4'd1;
      if (state == CAP) res_data <= mac_dout;
    end
  end

  always_comb begin
    // NOTE: every output gets a default before the case so no path infers a latch.
    state_nx     = state;
    busy         = 1'b1;
    rd_en        = 1'b0;
    act_addr     = '0;
    wgt_addr     = '0;
    mac_clr_n    = clr_n_q;
    mac_en       = 1'b0;
    mac_only_add = 1'b0;
    mac_a        = '0;
    mac_b        = '0;
    res_valid    = 1'b0;

    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nx = CLR;
      end
      CLR: begin
        mac_clr_n = 1'b0;
        state_nx  = RUN;
      end
      RUN: begin
        rd_en = (cnt < n_q);
        if (rd_en) begin
          act_addr = act_base_q + ADDR_W'(cnt);
          wgt_addr = wgt_base_q + ADDR_W'(cnt);
        end
        if (cnt == last_idx) state_nx = DRAIN;
      end
      DRAIN: state_nx = CAP;
      CAP:   state_nx = OUT;
      OUT: begin
        res_valid = 1'b1;
        if (res_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase

    // Bias at RUN i=0; tap_v cannot be high then since rd_en has not yet fired.
    if (state == RUN && cnt == 4'd0) begin
      mac_en       = 1'b1;
      mac_only_add = 1'b1;
      mac_a        = bias_q;
    end else if (tap_v) begin
      mac_en = 1'b1;
      mac_a  = act_rdata;
      mac_b  = wgt_rdata;
    end
  end

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Bench for mac_seq_ctrl: buffer + MAC stubs, a per-pixel schedule model checked
// every cycle, and directed pixels with hand-computed latency/result literals.
module tb_mac_seq_ctrl;
  localparam int ADDR_W = 8;
  localparam int KMAX   = 9;

  logic              clk = 1'b0;
  logic              rstn, start, res_ready;
  logic [3:0]        n_taps;
  logic [ADDR_W-1:0] act_base, wgt_base;
  logic [7:0]        bias;
  logic              busy, rd_en, mac_clr_n, mac_en, mac_only_add, res_valid;
  logic [ADDR_W-1:0] act_addr, wgt_addr;
  logic [7:0]        act_rdata, wgt_rdata, mac_a, mac_b, mac_dout, res_data;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mac_seq_ctrl #(.KMAX(KMAX), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rstn(rstn), .start(start), .n_taps(n_taps),
    .act_base(act_base), .wgt_base(wgt_base), .bias(bias),
    .busy(busy), .rd_en(rd_en), .act_addr(act_addr), .wgt_addr(wgt_addr),
    .act_rdata(act_rdata), .wgt_rdata(wgt_rdata),
    .mac_clr_n(mac_clr_n), .mac_en(mac_en), .mac_only_add(mac_only_add),
    .mac_a(mac_a), .mac_b(mac_b), .mac_dout(mac_dout),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Environment: synchronous-read buffers and the MAC (acc>>>8, ReLU, clip to 127).
  logic signed [7:0] act_mem [256];
  logic signed [7:0] wgt_mem [256];
  int acc = 0;

  function automatic logic [7:0] quant(input int a);
    int t;
    t = a >>> 8;
    if (t < 0)   return 8'd0;
    if (t > 127) return 8'd127;
    return t[7:0];
  endfunction

  always @(posedge clk)
    if (rd_en) begin
      act_rdata <= act_mem[act_addr];
      wgt_rdata <= wgt_mem[wgt_addr];
    end

  always @(posedge clk)
    if (!mac_clr_n) acc <= 0;
    else if (mac_en)
      acc <= mac_only_add ? acc + int'($signed(mac_a)) * 256
                          : acc + int'($signed(mac_a)) * int'($signed(mac_b));

  assign mac_dout = quant(acc);

  // Pixel-level model: k counts cycles since the start cycle (k=1 is the clear cycle).
  logic       m_init = 1'b0;
  logic       m_rst = 1'b0;
  logic       m_active = 1'b0;
  int         m_k = 0;
  int         m_n = 0;
  int         m_lat = 0;
  logic [7:0] m_ab, m_wb, m_bias, m_res;

  function automatic logic [7:0] expect_pixel(input int n, input logic [7:0] ab,
                                              input logic [7:0] wb, input logic [7:0] b);
    int s;
    s = int'($signed(b)) * 256;
    for (int i = 0; i < n; i++)
      s = s + int'(act_mem[8'(ab + i)]) * int'(wgt_mem[8'(wb + i)]);
    return quant(s);
  endfunction

  always @(posedge clk) begin
    int n_eff;
    m_init <= 1'b1;
    if (!rstn) begin
      m_rst    <= 1'b1;
      m_active <= 1'b0;
      m_k      <= 0;
    end else begin
      m_rst <= 1'b0;
      if (m_active) begin
        if (m_k >= m_lat && res_ready) m_active <= 1'b0;
        else                           m_k <= m_k + 1;
      end else if (start) begin
        n_eff    = (int'(n_taps) > KMAX) ? KMAX : int'(n_taps);
        m_active <= 1'b1;
        m_k      <= 1;
        m_n      <= n_eff;
        m_lat    <= ((n_eff > 1) ? n_eff : 1) + 4;
        m_ab     <= act_base;
        m_wb     <= wgt_base;
        m_bias   <= bias;
        m_res    <= expect_pixel(n_eff, act_base, wgt_base, bias);
      end
    end
  end

  // Free-running observation log for the directed literal checks.
  int         rd_total = 0;
  int         oa_total = 0;
  logic [7:0] oa_last_a = '0;
  logic [7:0] addr_hist [64];

  always @(negedge clk) begin : cmp
    logic [7:0] ea, eb, eaddr, ewaddr;
    logic       een, eoa, er;
    int         i, j;
    if (rd_en) begin
      addr_hist[rd_total % 64] = act_addr;
      rd_total++;
    end
    if (mac_only_add) begin
      oa_total++;
      oa_last_a = mac_a;
    end
    if (m_init) begin
      if (m_rst) begin
        check("rst_busy", busy, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_mac_clr_n", mac_clr_n, 0);
        check("rst_rd_en", rd_en, 0);
        check("rst_mac_en", mac_en, 0);
        check("rst_only_add", mac_only_add, 0);
        check("rst_act_addr", act_addr, 0);
        check("rst_wgt_addr", wgt_addr, 0);
      end else begin
        i   = m_k - 2;
        j   = m_k - 3;
        er  = m_active && i >= 0 && i < m_n;
        een = 1'b0; eoa = 1'b0; ea = '0; eb = '0;
        if (m_active && m_k == 2) begin
          een = 1'b1; eoa = 1'b1; ea = m_bias;
        end else if (m_active && j >= 0 && j < m_n) begin
          een = 1'b1;
          ea  = act_mem[8'(m_ab + j)];
          eb  = wgt_mem[8'(m_wb + j)];
        end
        check("busy", busy, m_active);
        check("mac_clr_n", mac_clr_n, !(m_active && m_k == 1));
        check("rd_en", rd_en, er);
        check("mac_en", mac_en, een);
        check("mac_only_add", mac_only_add, eoa);
        check("mac_a", mac_a, ea);
        check("mac_b", mac_b, eb);
        check("res_valid", res_valid, m_active && m_k >= m_lat);
        if (er) begin
          eaddr  = 8'(m_ab + i);
          ewaddr = 8'(m_wb + i);
          check("act_addr", act_addr, eaddr);
          check("wgt_addr", wgt_addr, ewaddr);
        end
        if (m_active && m_k >= m_lat) check("res_data", res_data, m_res);
      end
    end
  end

  task automatic fill(input int av, input int wv);
    for (int a = 0; a < 256; a++) begin
      act_mem[a] = 8'(av);
      wgt_mem[a] = 8'(wv);
    end
  endtask

  // Called #1 after an edge; returns #1 into cycle 1 (the clear cycle).
  task automatic start_pixel(input int n, input int ab, input int wb, input int b);
    start    = 1'b1;
    n_taps   = 4'(n);
    act_base = 8'(ab);
    wgt_base = 8'(wb);
    bias     = 8'(b);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Leaves the caller at the negedge of the first res_valid cycle.
  task automatic wait_valid(output int lat, output logic [7:0] data);
    int c;
    c    = 1;
    lat  = -1;
    data = '0;
    while (c < 60) begin
      @(negedge clk);
      if (res_valid) begin
        lat  = c;
        data = res_data;
        break;
      end
      @(posedge clk); #1;
      c++;
    end
    if (lat < 0) check("res_valid_timeout", 0, 1);
  endtask

  task automatic run_pixel(input string name, input int n, input int ab, input int wb,
                           input int b, input int exp_lat, input int exp_res);
    int         lat;
    logic [7:0] data;
    start_pixel(n, ab, wb, b);
    wait_valid(lat, data);
    check({name, "_latency"}, lat, exp_lat);
    check({name, "_result"}, data, exp_res);
    @(posedge clk); #1;
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int         rd0, oa0, lat;
    logic [7:0] data;
    rstn = 1'b0; start = 1'b1; res_ready = 1'b1;
    n_taps = '0; act_base = '0; wgt_base = '0; bias = '0;
    fill(16, 16);

    // Reset held with start high.
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("lit_rst_busy", busy, 0);
    check("lit_rst_clr_n", mac_clr_n, 0);
    check("lit_rst_rd_en", rd_en, 0);
    @(posedge clk); #1;
    rstn = 1'b1; start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("lit_idle_after_rst", busy, 0);
    @(posedge clk); #1;

    // Nine taps of 16*16: 2304 >>> 8 = 9.
    rd0 = rd_total;
    run_pixel("full9", 9, 10, 100, 0, 13, 9);
    check("full9_rd_cycles", rd_total - rd0, 9);
    check("full9_first_addr", addr_hist[rd0 % 64], 10);
    check("full9_last_addr", addr_hist[(rd0 + 8) % 64], 18);

    // Negative accumulation: 512 - 2304 < 0 -> ReLU 0; one bias cycle with a=2.
    fill(16, -16);
    oa0 = oa_total;
    rd0 = rd_total;
    run_pixel("neg9", 9, 0, 0, 2, 13, 0);
    check("neg9_only_add_cycles", oa_total - oa0, 1);
    check("neg9_bias_a", oa_last_a, 2);

    // Zero taps: bias only.
    rd0 = rd_total;
    run_pixel("zero", 0, 5, 5, 7, 5, 7);
    check("zero_rd_cycles", rd_total - rd0, 0);

    // Address wrap: acts 1,2,3,4 at 254,255,0,1; wgt 64; bias 1 -> (256+640)>>>8 = 3.
    fill(16, 64);
    act_mem[254] = 8'sd1; act_mem[255] = 8'sd2; act_mem[0] = 8'sd3; act_mem[1] = 8'sd4;
    rd0 = rd_total;
    run_pixel("wrap", 4, 254, 0, 1, 8, 3);
    check("wrap_addr0", addr_hist[rd0 % 64], 254);
    check("wrap_addr1", addr_hist[(rd0 + 1) % 64], 255);
    check("wrap_addr2", addr_hist[(rd0 + 2) % 64], 0);
    check("wrap_addr3", addr_hist[(rd0 + 3) % 64], 1);

    // Clamp: n_taps=15 behaves as 9.
    fill(16, 16);
    rd0 = rd_total;
    run_pixel("clamp", 15, 40, 80, 0, 13, 9);
    check("clamp_rd_cycles", rd_total - rd0, 9);

    // Large positive sum saturates: 127*127*9 >>> 8 > 127.
    fill(127, 127);
    run_pixel("sat", 9, 0, 0, 0, 13, 127);

    // Backpressure: two taps + bias 5 -> (1280+512)>>>8 = 7, held while res_ready=0.
    fill(16, 16);
    res_ready = 1'b0;
    start_pixel(2, 20, 30, 5);
    wait_valid(lat, data);
    check("bp_latency", lat, 6);
    check("bp_result", data, 7);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      start = (c == 2);
      @(negedge clk);
      check("bp_busy", busy, 1);
      check("bp_valid_held", res_valid, 1);
      check("bp_data_held", res_data, 7);
    end
    start = 1'b0;
    res_ready = 1'b1;
    @(posedge clk); #1;
    run_pixel("after_bp", 0, 0, 0, 3, 5, 3);

    // Reset in RUN at i=3, then a clean pixel: 256 + 3*256 -> 4.
    start_pixel(9, 0, 0, 0);
    repeat (4) @(posedge clk);
    #1;
    rstn = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_rd_en", rd_en, 0);
    check("abort_mac_en", mac_en, 0);
    check("abort_clr_n", mac_clr_n, 0);
    rstn = 1'b1;
    @(posedge clk); #1;
    run_pixel("post_abort", 3, 7, 9, 1, 7, 4);

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
